// File: rtl/led_scanner.sv
// Scans eight segment buses onto one shared bus with a rotating one-hot digit select.
// Outputs are registered one cycle after cnt/idx/shadow; en=0 holds the scan and blanks the display.
module led_scanner #(
  parameter int DIV   = 1000,
  parameter int BLANK = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] seg_a,
  input  logic [7:0] seg_b,
  input  logic [7:0] seg_c,
  input  logic [7:0] seg_d,
  input  logic [7:0] seg_e,
  input  logic [7:0] seg_f,
  input  logic [7:0] seg_g,
  input  logic [7:0] seg_h,
  output logic [7:0] seg_out,
  output logic [7:0] controll,
  output logic       frame_tick
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shadow [8];
  logic          r_first;
  logic [7:0]    r_seg_out;
  logic [7:0]    r_controll;
  logic          r_frame_tick;

  logic [7:0]    w_seg_in [8];
  logic          w_last;
  logic          w_cap;
  logic          w_blank;
  logic [7:0]    w_disp;

  assign w_seg_in[0] = seg_a;
  assign w_seg_in[1] = seg_b;
  assign w_seg_in[2] = seg_c;
  assign w_seg_in[3] = seg_d;
  assign w_seg_in[4] = seg_e;
  assign w_seg_in[5] = seg_f;
  assign w_seg_in[6] = seg_g;
  assign w_seg_in[7] = seg_h;

  assign w_last = (r_cnt == CNT_LAST);
  // Wrap capture lands in digit 7's final cycle so the next frame opens on fresh data.
  assign w_cap  = en & (r_first | (w_last & (r_idx == 3'd7)));

  // Before the very first snapshot the shadow is still empty, so show the live input instead.
  assign w_disp = r_first ? w_seg_in[r_idx] : r_shadow[r_idx];

  generate
    if (BLANK == 0) begin : g_no_blank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (r_cnt < CW'(BLANK));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_first <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        r_shadow[i] <= 8'h00;
      end
    end else begin
      if (en) begin
        if (w_last) begin
          r_cnt <= '0;
          r_idx <= r_idx + 3'd1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if (w_cap) begin
        r_first <= 1'b0;
        for (int i = 0; i < 8; i++) begin
          r_shadow[i] <= w_seg_in[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seg_out    <= 8'h00;
      r_controll   <= 8'h00;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_cap;
      if (en && !w_blank) begin
        r_seg_out  <= w_disp;
        r_controll <= 8'h01 << r_idx;
      end else begin
        r_seg_out  <= 8'h00;
        r_controll <= 8'h00;
      end
    end
  end

  assign seg_out    = r_seg_out;
  assign controll   = r_controll;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_led_scanner.sv
// Directed bench for led_scanner: DIV=8/BLANK=2 main instance plus a DIV=2/BLANK=0 instance.
module tb_led_scanner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [7:0] seg [8];
  logic [7:0] so1, c1, so2, c2;
  logic       ft1, ft2;

  always #5 clk = ~clk;

  led_scanner #(.DIV(8), .BLANK(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .seg_a(seg[0]), .seg_b(seg[1]), .seg_c(seg[2]), .seg_d(seg[3]),
    .seg_e(seg[4]), .seg_f(seg[5]), .seg_g(seg[6]), .seg_h(seg[7]),
    .seg_out(so1), .controll(c1), .frame_tick(ft1)
  );

  led_scanner #(.DIV(2), .BLANK(0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .en(en),
    .seg_a(seg[0]), .seg_b(seg[1]), .seg_c(seg[2]), .seg_d(seg[3]),
    .seg_e(seg[4]), .seg_f(seg[5]), .seg_g(seg[6]), .seg_h(seg[7]),
    .seg_out(so2), .controll(c2), .frame_tick(ft2)
  );

  int         n_chk  = 0;
  int         n_pass = 0;
  int         tv;
  bit         chk2;
  logic [7:0] sh1 [8];
  logic [7:0] sh2 [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s tv=%0d: got %0h expected %0h", tag, tv, obs, exp);
  endtask

  // tv counts enabled scan cycles since reset; expected values follow from it.
  task automatic step();
    logic       en_at;
    int         c, d;
    logic [7:0] e_seg, e_ctl;
    en_at = en;
    @(posedge clk);
    @(negedge clk);
    if (en_at) begin
      c = tv % 8;
      d = (tv / 8) % 8;
      e_seg = (c < 2) ? 8'h00 : sh1[d];
      e_ctl = (c < 2) ? 8'h00 : (8'h01 << d);
      chk("seg1", so1, e_seg);
      chk("ctl1", c1, e_ctl);
      chk("ft1", ft1, (tv == 0) || (tv % 64 == 63));
      if (tv == 63) chk("wrap_last_d7", c1, 8'h80);
      if (tv == 64) chk("wrap_blank", c1, 8'h00);
      if (tv == 66) chk("wrap_d0", c1, 8'h01);
      if (tv == 82) chk("d2_old", so1, 8'h03);
      if (tv == 146) chk("d2_new", so1, 8'hFF);
      if (chk2) begin
        d = (tv / 2) % 8;
        if (tv != 0) chk("seg2", so2, sh2[d]);
        chk("ctl2", c2, 8'h01 << d);
        chk("ft2", ft2, (tv == 0) || (tv % 16 == 15));
      end
      if ((tv == 0) || (tv % 64 == 63)) sh1 = seg;
      if ((tv == 0) || (tv % 16 == 15)) sh2 = seg;
      tv++;
    end else begin
      chk("pause_seg", so1, 8'h00);
      chk("pause_ctl", c1, 8'h00);
      chk("pause_ft", ft1, 1'b0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en      = 1'b1;
    chk2    = 1'b0;
    tv      = 0;
    for (int i = 0; i < 8; i++) begin
      seg[i] = 8'(i + 1);
      sh1[i] = 8'h00;
      sh2[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("rst_seg1", so1, 8'h00);
    chk("rst_ctl1", c1, 8'h00);
    chk("rst_ft1", ft1, 1'b0);
    chk("rst_seg2", so2, 8'h00);
    chk("rst_ctl2", c2, 8'h00);
    chk("rst_ft2", ft2, 1'b0);
    reset_n = 1'b1;

    // Frame 0 and into frame 1, then change seg_c during digit 1.
    repeat (75) step();
    seg[2] = 8'hFF;

    // Run to digit 3, cnt=5 of frame 3 and pause for 10 cycles.
    repeat (146) step();
    en = 1'b0;
    repeat (10) step();
    en = 1'b1;
    step();
    chk("resume_ctl", c1, 8'h08);
    chk("resume_seg", so1, 8'h04);

    // Advance into digit 4, then reset asynchronously between edges.
    repeat (5) step();
    chk("pre_rst_ctl", c1, 8'h10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_seg1", so1, 8'h00);
    chk("arst_ctl1", c1, 8'h00);
    chk("arst_ft1", ft1, 1'b0);
    chk("arst_ctl2", c2, 8'h00);
    for (int i = 0; i < 8; i++) begin
      seg[i] = 8'(8'h21 + i);
      sh1[i] = 8'h00;
      sh2[i] = 8'h00;
    end
    tv   = 0;
    chk2 = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (72) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
